fp_mul_arb: RTL and testbench



---
 rtl/fp_mul_arb.sv | 118 +++++++++++
 tb/tb_fp_mul_arb.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_mul_arb.sv
// rtl/fp_mul_arb.sv - round-robin arbiter sharing one pipelined multiplier among NUM_REQ requesters
// Optional issue/conflict counters are built when FP_MUL_ARB_STATS_EN is defined.
module fp_mul_arb #(
  parameter int WIDTH   = 16,
  parameter int NUM_REQ = 4,
  parameter int MUL_LAT = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic [WIDTH-1:0]         mul_a,
  output logic [WIDTH-1:0]         mul_b,
  input  logic [WIDTH-1:0]         mul_result,
  output logic [NUM_REQ-1:0]       rsp_valid,
  output logic [WIDTH-1:0]         rsp_result,
  output logic                     busy
`ifdef FP_MUL_ARB_STATS_EN
  ,
  input  logic                     stat_clr,
  output logic [31:0]              stat_issue,
  output logic [31:0]              stat_conflict
`endif
);
  localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [ID_W-1:0]  rr_ptr;
  logic [ID_W-1:0]  gnt_id;
  logic             gnt_any;
  logic [ID_W:0]    pos;
  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];
  logic [MUL_LAT:0] tag_v;
  logic [ID_W-1:0]  tag_id [MUL_LAT+1];

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      a_arr[i] = req_a[i*WIDTH +: WIDTH];
      b_arr[i] = req_b[i*WIDTH +: WIDTH];
    end
  end

  // Search from rr_ptr upward; pos carries one extra bit so the wrap works for any NUM_REQ.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    pos     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      pos = {1'b0, rr_ptr} + (ID_W+1)'(i);
      if (pos >= (ID_W+1)'(NUM_REQ))
        pos = pos - (ID_W+1)'(NUM_REQ);
      if (!gnt_any && req_valid[pos[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = pos[ID_W-1:0];
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (gnt_any && rst_n)
      req_ready[gnt_id] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      mul_a  <= '0;
      mul_b  <= '0;
      tag_v  <= '0;
      for (int i = 0; i <= MUL_LAT; i++)
        tag_id[i] <= '0;
    end else begin
      tag_v     <= {tag_v[MUL_LAT-1:0], gnt_any};
      tag_id[0] <= gnt_id;
      for (int i = 1; i <= MUL_LAT; i++)
        tag_id[i] <= tag_id[i-1];
      if (gnt_any) begin
        mul_a  <= a_arr[gnt_id];
        mul_b  <= b_arr[gnt_id];
        rr_ptr <= (gnt_id == ID_W'(NUM_REQ-1)) ? '0 : gnt_id + ID_W'(1);
      end
    end
  end

  // The last tag stage lines up with mul_result for the op issued MUL_LAT+1 edges earlier.
  always_comb begin
    rsp_valid = '0;
    if (tag_v[MUL_LAT])
      rsp_valid[tag_id[MUL_LAT]] = 1'b1;
  end

  assign rsp_result = mul_result;
  assign busy       = |tag_v;

`ifdef FP_MUL_ARB_STATS_EN
  logic conflict;
  assign conflict = (req_valid & (req_valid - NUM_REQ'(1))) != '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issue    <= '0;
      stat_conflict <= '0;
    end else if (stat_clr) begin
      stat_issue    <= '0;
      stat_conflict <= '0;
    end else begin
      if (gnt_any && stat_issue != '1)
        stat_issue <= stat_issue + 32'd1;
      if (conflict && stat_conflict != '1)
        stat_conflict <= stat_conflict + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fp_mul_arb.sv
// tb/tb_fp_mul_arb.sv - self-checking bench for fp_mul_arb with a behavioural arbiter/multiplier model
// Stats checks are compiled when FP_MUL_ARB_STATS_EN is defined.
module tb_fp_mul_arb;
  localparam int W = 16;
  localparam int N = 4;
  localparam int L = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic [N-1:0]     req_valid, req_ready, rsp_valid;
  logic [N*W-1:0]   req_a, req_b;
  logic [W-1:0]     mul_a, mul_b, mul_result, rsp_result;
  logic             busy;
  logic [2:0]       r3_valid, r3_ready, r3_rsp_valid;
  logic [3*W-1:0]   r3_a, r3_b;
  logic [W-1:0]     m3_a, m3_b, m3_result, r3_result;
  logic             busy3;
`ifdef FP_MUL_ARB_STATS_EN
  logic             stat_clr;
  logic [31:0]      stat_issue, stat_conflict, s3_issue, s3_conflict;
`endif

  logic [W-1:0] mpipe  [L];
  logic [W-1:0] mpipe3 [L];

  // fp16 product of normal numbers, truncated; stands in for the real multiplier.
  function automatic logic [W-1:0] fp_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic        s;
    int          e;
    logic [21:0] p;
    s = a[15] ^ b[15];
    if (a[14:0] == 15'd0 || b[14:0] == 15'd0) return {s, 15'd0};
    e = int'(a[14:10]) + int'(b[14:10]) - 15;
    p = 22'({1'b1, a[9:0]}) * 22'({1'b1, b[9:0]});
    if (p[21]) begin
      e = e + 1;
      return {s, e[4:0], p[20:11]};
    end
    return {s, e[4:0], p[19:10]};
  endfunction

  always @(posedge clk) begin
    mpipe[0]  <= fp_mul(mul_a, mul_b);
    mpipe3[0] <= fp_mul(m3_a, m3_b);
    for (int i = 1; i < L; i++) begin
      mpipe[i]  <= mpipe[i-1];
      mpipe3[i] <= mpipe3[i-1];
    end
  end
  assign mul_result = mpipe[L-1];
  assign m3_result  = mpipe3[L-1];

  fp_mul_arb #(.WIDTH(W), .NUM_REQ(N), .MUL_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .mul_a(mul_a), .mul_b(mul_b),
    .mul_result(mul_result), .rsp_valid(rsp_valid), .rsp_result(rsp_result), .busy(busy)
`ifdef FP_MUL_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_issue(stat_issue), .stat_conflict(stat_conflict)
`endif
  );

  fp_mul_arb #(.WIDTH(W), .NUM_REQ(3), .MUL_LAT(L)) dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(r3_valid), .req_ready(r3_ready),
    .req_a(r3_a), .req_b(r3_b), .mul_a(m3_a), .mul_b(m3_b),
    .mul_result(m3_result), .rsp_valid(r3_rsp_valid), .rsp_result(r3_result), .busy(busy3)
`ifdef FP_MUL_ARB_STATS_EN
    , .stat_clr(stat_clr), .stat_issue(s3_issue), .stat_conflict(s3_conflict)
`endif
  );

  typedef struct {int due; int id; logic [W-1:0] res;} rsp_t;

  bit           pend [N];
  logic [W-1:0] pa [N];
  logic [W-1:0] pb [N];
  rsp_t         q [$];
  int           mptr, cyc, n_chk, n_fail;

  function automatic int model_grant(input logic [15:0] v, input int ptr, input int n);
    int idx;
    for (int k = 0; k < n; k++) begin
      idx = (ptr + k) % n;
      if (v[idx[3:0]]) return idx;
    end
    return -1;
  endfunction

  task automatic refill(input logic [N-1:0] mask);
    for (int i = 0; i < N; i++)
      if (mask[i] && !pend[i]) begin
        pend[i] = 1'b1;
        pa[i]   = W'($urandom);
        pb[i]   = W'($urandom);
      end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      req_valid[i]       = pend[i];
      req_a[i*W +: W]    = pa[i];
      req_b[i*W +: W]    = pb[i];
    end
  endtask

  // Commits the model's view of the upcoming edge, then advances one clock.
  task automatic model_edge();
    int g;
    while (q.size() > 0 && q[0].due <= cyc) void'(q.pop_front());
    g = model_grant(16'(req_valid), mptr, N);
    if (g >= 0) begin
      q.push_back('{cyc + L + 1, g, fp_mul(pa[g], pb[g])});
      pend[g] = 1'b0;
      mptr    = (g + 1) % N;
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    refill('1);
    drive();
    r3_valid = 3'b111;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (req_ready !== '0) begin n_fail++; $display("FAIL reset_ready got=%b exp=0000", req_ready); end
    n_chk++; if (r3_ready !== '0) begin n_fail++; $display("FAIL reset_ready3 got=%b exp=000", r3_ready); end
    n_chk++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL reset_rsp got=%b exp=0000", rsp_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_chk++; if (mul_a !== '0 || mul_b !== '0) begin n_fail++; $display("FAIL reset_mul got=%h/%h exp=0000/0000", mul_a, mul_b); end
    @(posedge clk);
    #1;
    r3_valid = '0;
    rst_n = 1'b1;
    cyc = 0;
    mptr = 0;
  endtask

  task automatic test_all_four();
    logic [N-1:0] ev, er;
    logic [W-1:0] eres;
    int eg;
    for (int k = 0; k < 10; k++) begin
      drive();
      @(negedge clk);
      eg = model_grant(16'(req_valid), mptr, N);
      ev = (eg >= 0) ? (N'(1) << eg) : '0;
      n_chk++; if (req_ready !== ev) begin n_fail++; $display("FAIL all4_grant k=%0d got=%b exp=%b", k, req_ready, ev); end
      if (k < 4) begin
        n_chk++; if (req_ready !== N'(1) << k) begin n_fail++; $display("FAIL all4_order k=%0d got=%b exp=%b", k, req_ready, N'(1) << k); end
      end
      er = '0; eres = '0;
      if (q.size() > 0 && q[0].due == cyc) begin er = N'(1) << q[0].id; eres = q[0].res; end
      if (k >= 5 && k <= 8) begin
        n_chk++; if (rsp_valid !== N'(1) << (k-5)) begin n_fail++; $display("FAIL all4_rsp_order k=%0d got=%b exp=%b", k, rsp_valid, N'(1) << (k-5)); end
      end
      n_chk++; if (rsp_valid !== er) begin n_fail++; $display("FAIL all4_rsp k=%0d got=%b exp=%b", k, rsp_valid, er); end
      if (er != '0) begin
        n_chk++; if (rsp_result !== eres) begin n_fail++; $display("FAIL all4_data k=%0d got=%h exp=%h", k, rsp_result, eres); end
      end
      model_edge();
    end
  endtask

  task automatic test_single();
    logic exp_busy;
    pend[2] = 1'b1; pa[2] = 16'h3C00; pb[2] = 16'h4000;
    for (int k = 0; k < 8; k++) begin
      drive();
      @(negedge clk);
      if (k == 0) begin
        n_chk++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_grant got=%b exp=0100", req_ready); end
      end
      if (k == 1) begin
        n_chk++; if (mul_a !== 16'h3C00 || mul_b !== 16'h4000) begin n_fail++; $display("FAIL single_mul got=%h/%h exp=3c00/4000", mul_a, mul_b); end
      end
      exp_busy = (k >= 1 && k <= 5);
      n_chk++; if (busy !== exp_busy) begin n_fail++; $display("FAIL single_busy k=%0d got=%b exp=%b", k, busy, exp_busy); end
      n_chk++; if (rsp_valid !== ((k == 5) ? 4'b0100 : 4'b0000)) begin n_fail++; $display("FAIL single_rsp k=%0d got=%b", k, rsp_valid); end
      if (k == 5) begin
        n_chk++; if (rsp_result !== 16'h4000) begin n_fail++; $display("FAIL single_data got=%h exp=4000", rsp_result); end
      end
      model_edge();
    end
  endtask

  task automatic test_alternate();
    logic [N-1:0] ev, prev;
    int eg;
    prev = '0;
    for (int k = 0; k < 10; k++) begin
      refill(4'b1010);
      drive();
      @(negedge clk);
      eg = model_grant(16'(req_valid), mptr, N);
      ev = (eg >= 0) ? (N'(1) << eg) : '0;
      n_chk++; if (req_ready !== ev) begin n_fail++; $display("FAIL alt_grant k=%0d got=%b exp=%b", k, req_ready, ev); end
      if (k > 0) begin
        n_chk++; if (req_ready === prev) begin n_fail++; $display("FAIL alt_repeat k=%0d got=%b exp=not %b", k, req_ready, prev); end
      end
      prev = req_ready;
      model_edge();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] ev, er;
    logic [W-1:0] eres;
    int eg;
    for (int k = 0; k < 80; k++) begin
      if (k < 70) refill(N'($urandom));
      drive();
      @(negedge clk);
      eg = model_grant(16'(req_valid), mptr, N);
      ev = (eg >= 0) ? (N'(1) << eg) : '0;
      n_chk++; if (req_ready !== ev) begin n_fail++; $display("FAIL rnd_grant k=%0d got=%b exp=%b", k, req_ready, ev); end
      er = '0; eres = '0;
      if (q.size() > 0 && q[0].due == cyc) begin er = N'(1) << q[0].id; eres = q[0].res; end
      n_chk++; if (rsp_valid !== er) begin n_fail++; $display("FAIL rnd_rsp k=%0d got=%b exp=%b", k, rsp_valid, er); end
      if (er != '0) begin
        n_chk++; if (rsp_result !== eres) begin n_fail++; $display("FAIL rnd_data k=%0d got=%h exp=%h", k, rsp_result, eres); end
      end
      n_chk++; if (busy !== (q.size() > 0)) begin n_fail++; $display("FAIL rnd_busy k=%0d got=%b exp=%b", k, busy, q.size() > 0); end
      model_edge();
    end
  endtask

  task automatic test_reset_midflight();
    logic [N-1:0] er;
    refill(4'b1110);
    for (int k = 0; k < 3; k++) begin
      drive();
      model_edge();
    end
    refill('1);
    drive();
    rst_n = 1'b0;
    #1;
    n_chk++; if (rsp_valid !== '0) begin n_fail++; $display("FAIL mid_rsp got=%b exp=0000", rsp_valid); end
    n_chk++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy got=%b exp=0", busy); end
    n_chk++; if (req_ready !== '0) begin n_fail++; $display("FAIL mid_ready got=%b exp=0000", req_ready); end
    q.delete();
    mptr = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      drive();
      @(negedge clk);
      if (k == 0) begin
        n_chk++; if (req_ready !== 4'b0001) begin n_fail++; $display("FAIL mid_first_grant got=%b exp=0001", req_ready); end
      end
      er = '0;
      if (q.size() > 0 && q[0].due == cyc) er = N'(1) << q[0].id;
      n_chk++; if (rsp_valid !== er) begin n_fail++; $display("FAIL mid_stale k=%0d got=%b exp=%b", k, rsp_valid, er); end
      model_edge();
    end
  endtask

  task automatic test_wrap3();
    logic [2:0] vin  [4];
    logic [2:0] expg [4];
    vin  = '{3'b010, 3'b101, 3'b101, 3'b101};
    expg = '{3'b010, 3'b100, 3'b001, 3'b100};
    r3_a = {16'h4200, 16'h4000, 16'h3C00};
    r3_b = {16'h3C00, 16'h4400, 16'h4000};
    for (int k = 0; k < 10; k++) begin
      r3_valid = (k < 4) ? vin[k] : 3'b000;
      @(negedge clk);
      if (k < 4) begin
        n_chk++; if (r3_ready !== expg[k]) begin n_fail++; $display("FAIL wrap3_grant k=%0d got=%b exp=%b", k, r3_ready, expg[k]); end
      end
      if (k >= 5 && k <= 8) begin
        n_chk++; if (r3_rsp_valid !== expg[k-5]) begin n_fail++; $display("FAIL wrap3_rsp k=%0d got=%b exp=%b", k, r3_rsp_valid, expg[k-5]); end
      end
      @(posedge clk);
      #1;
    end
  endtask

`ifdef FP_MUL_ARB_STATS_EN
  task automatic test_stats();
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    stat_clr = 1'b1;
    model_edge();
    stat_clr = 1'b0;
    @(negedge clk);
    n_chk++; if (stat_issue !== 32'd0 || stat_conflict !== 32'd0) begin n_fail++; $display("FAIL stats_clr0 got=%0d/%0d exp=0/0", stat_issue, stat_conflict); end
    @(posedge clk);
    #1;
    cyc++;
    for (int k = 0; k < 6; k++) begin
      refill('1);
      drive();
      model_edge();
    end
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    @(negedge clk);
    n_chk++; if (stat_issue !== 32'd6) begin n_fail++; $display("FAIL stats_issue got=%0d exp=6", stat_issue); end
    n_chk++; if (stat_conflict !== 32'd6) begin n_fail++; $display("FAIL stats_conflict got=%0d exp=6", stat_conflict); end
    @(posedge clk);
    #1;
    cyc++;
    stat_clr = 1'b1;
    refill('1);
    drive();
    model_edge();
    stat_clr = 1'b0;
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    drive();
    @(negedge clk);
    n_chk++; if (stat_issue !== 32'd0 || stat_conflict !== 32'd0) begin n_fail++; $display("FAIL stats_clr_wins got=%0d/%0d exp=0/0", stat_issue, stat_conflict); end
  endtask
`endif

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0; mptr = 0;
    req_valid = '0; req_a = '0; req_b = '0;
    r3_valid = '0; r3_a = '0; r3_b = '0;
`ifdef FP_MUL_ARB_STATS_EN
    stat_clr = 1'b0;
`endif
    test_reset();
    test_all_four();
    test_single();
    test_alternate();
    test_back_to_back();
    test_reset_midflight();
    test_wrap3();
`ifdef FP_MUL_ARB_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
